// File: rtl/axi_master_if.sv
// rtl/axi_master_if.sv - single-outstanding AXI4 master for one CPU memory port
// Turns a CPU request into one single-beat AXI4 read or write and stalls the core until it completes.
module axi_master_if #(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M,
    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,
    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M
);

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, r_fire, b_fire;

    assign aw_hs  = AWVALID_M & AWREADY_M;
    assign w_hs   = WVALID_M & WREADY_M;
    assign r_fire = (state == R) & RVALID_M;
    assign b_fire = (state == B) & BVALID_M;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == AWW) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (r_fire) rdata_q <= RDATA_M;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_i) state_nxt = we_i ? AWW : AR;
            AR:   if (ARREADY_M) state_nxt = R;
            R:    if (RVALID_M) state_nxt = IDLE;
            // Each channel may complete in any cycle; leave once both have.
            AWW:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = B;
            B:    if (BVALID_M) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;
    assign AWVALID_M = (state == AWW) & ~aw_done;
    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;
    assign WLAST_M   = 1'b1;
    assign WVALID_M  = (state == AWW) & ~w_done;
    assign BREADY_M  = (state == B);
    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;
    assign ARVALID_M = (state == AR);
    assign RREADY_M  = (state == R);

    assign done_o  = r_fire | b_fire;
    assign err_o   = (r_fire & ((RRESP_M != 2'b00) | (RID_M != MASTER_ID)))
                   | (b_fire & ((BRESP_M != 2'b00) | (BID_M != MASTER_ID)));
    assign stall_o = ((state == IDLE) & req_i) | ((state != IDLE) & ~done_o);
    assign rdata_o = r_fire ? RDATA_M : rdata_q;

    logic unused_ok;
    assign unused_ok = RLAST_M;

endmodule

// File: tb/tb_axi_master_if.sv
// tb/tb_axi_master_if.sv - directed vector bench for axi_master_if
module tb_axi_master_if;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic [31:0] rdata_o;
    logic        stall_o, done_o, err_o;
    logic [3:0]  AWID_M;
    logic [31:0] AWADDR_M;
    logic [3:0]  AWLEN_M;
    logic [2:0]  AWSIZE_M;
    logic [1:0]  AWBURST_M;
    logic        AWVALID_M, AWREADY_M;
    logic [31:0] WDATA_M;
    logic [3:0]  WSTRB_M;
    logic        WLAST_M, WVALID_M, WREADY_M;
    logic [3:0]  BID_M;
    logic [1:0]  BRESP_M;
    logic        BVALID_M, BREADY_M;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M, ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M, RVALID_M, RREADY_M;

    axi_master_if #(.MASTER_ID(4'd0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic        arready, rvalid, awready, wready, bvalid;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [7:0]  exp_ctl;
        logic [31:0] exp_rdata, exp_addr;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {ARVALID, RREADY, AWVALID, WVALID, BREADY, done, err, stall}
    function automatic logic [7:0] ctl();
        return {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, done_o, err_o, stall_o};
    endfunction

    task automatic clear_in();
        req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; wstrb_i = 4'd0;
        AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0; BID_M = 4'd0; BRESP_M = 2'd0;
        ARREADY_M = 1'b0; RVALID_M = 1'b0; RID_M = 4'd0; RDATA_M = 32'd0; RRESP_M = 2'd0;
        RLAST_M = 1'b1;
    endtask

    task automatic add(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ar, input logic rv, input logic aw,
                       input logic wr, input logic bv, input logic [31:0] rd, input logic [1:0] rs,
                       input logic [3:0] id, input logic [7:0] ec, input logic [31:0] er,
                       input logic [31:0] ea);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wdata = wd; v.wstrb = ws;
        v.arready = ar; v.rvalid = rv; v.awready = aw; v.wready = wr; v.bvalid = bv;
        v.rdata = rd; v.resp = rs; v.id = id; v.exp_ctl = ec; v.exp_rdata = er; v.exp_addr = ea;
        vq.push_back(v);
    endtask

    task automatic step();
        @(negedge ACLK);
        clear_in();
    endtask

    initial begin
        clear_in();
        ARESET = 1'b1;
        #1;
        check("reset_ctl", {24'd0, ctl()}, 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("const_len_size_burst", {21'd0, ARLEN_M, ARSIZE_M, AWBURST_M, AWID_M},
              {21'd0, 4'd0, 3'b010, 2'b01, 4'd0});
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;

        //   req   we    addr          wdata         wstrb  ar    rv    aw    w     bv    rdata         resp   id     ctl           rdata_o       addr
        add(1'b1, 1'b0, 32'h10000004, 32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0001, 32'd0,        32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b1000_0001, 32'd0,        32'h10000004);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 2'd0, 4'd0, 8'b0100_0100, 32'hDEADBEEF, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55555555, 2'd0, 4'd0, 8'b0000_0000, 32'hDEADBEEF, 32'd0);
        add(1'b1, 1'b1, 32'h20000008, 32'h12345678, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0001, 32'hDEADBEEF, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,        2'd0, 4'd0, 8'b0011_0001, 32'hDEADBEEF, 32'h20000008);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        2'd0, 4'd0, 8'b0001_0001, 32'hDEADBEEF, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,        2'd0, 4'd0, 8'b0001_0001, 32'hDEADBEEF, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        2'd0, 4'd0, 8'b0000_1100, 32'hDEADBEEF, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        2'd0, 4'd0, 8'b0000_0000, 32'hDEADBEEF, 32'd0);
        add(1'b1, 1'b0, 32'h00000003, 32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0001, 32'hDEADBEEF, 32'd0);
        add(1'b1, 1'b1, 32'hFFFFFFFF, 32'd0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b1000_0001, 32'hDEADBEEF, 32'h00000003);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 2'd2, 4'd0, 8'b0100_0110, 32'hCAFEF00D, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0000, 32'hCAFEF00D, 32'd0);
        add(1'b1, 1'b1, 32'h00000004, 32'h000000AA, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0001, 32'hCAFEF00D, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0011_0001, 32'hCAFEF00D, 32'h00000004);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        2'd0, 4'd3, 8'b0000_1110, 32'hCAFEF00D, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0000, 32'hCAFEF00D, 32'd0);
        add(1'b1, 1'b0, 32'h00000008, 32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0001, 32'hCAFEF00D, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b1000_0001, 32'hCAFEF00D, 32'h00000008);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11111111, 2'd0, 4'd5, 8'b0100_0110, 32'h11111111, 32'd0);
        add(1'b0, 1'b0, 32'd0,        32'd0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        2'd0, 4'd0, 8'b0000_0000, 32'h11111111, 32'd0);

        foreach (vq[i]) begin
            @(negedge ACLK);
            req_i = vq[i].req; we_i = vq[i].we; addr_i = vq[i].addr;
            wdata_i = vq[i].wdata; wstrb_i = vq[i].wstrb;
            ARREADY_M = vq[i].arready; RVALID_M = vq[i].rvalid; RDATA_M = vq[i].rdata;
            RRESP_M = vq[i].resp; RID_M = vq[i].id;
            AWREADY_M = vq[i].awready; WREADY_M = vq[i].wready; BVALID_M = vq[i].bvalid;
            BRESP_M = vq[i].resp; BID_M = vq[i].id;
            #1;
            check($sformatf("vec%0d_ctl", i), {24'd0, ctl()}, {24'd0, vq[i].exp_ctl});
            check($sformatf("vec%0d_rdata", i), rdata_o, vq[i].exp_rdata);
            if (vq[i].exp_ctl[7]) check($sformatf("vec%0d_araddr", i), ARADDR_M, vq[i].exp_addr);
            if (vq[i].exp_ctl[5]) check($sformatf("vec%0d_awaddr", i), AWADDR_M, vq[i].exp_addr);
        end

        // ARREADY held off for five cycles
        step(); req_i = 1'b1; addr_i = 32'h00000040;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            check($sformatf("arwait%0d_ctl", k), {24'd0, ctl()}, {24'd0, 8'b1000_0001});
            check($sformatf("arwait%0d_addr", k), ARADDR_M, 32'h00000040);
        end
        step(); ARREADY_M = 1'b1; #1;
        check("arwait_hs_ctl", {24'd0, ctl()}, {24'd0, 8'b1000_0001});
        step(); RVALID_M = 1'b1; RDATA_M = 32'hA5A5A5A5; #1;
        check("arwait_done_ctl", {24'd0, ctl()}, {24'd0, 8'b0100_0100});
        check("arwait_rdata", rdata_o, 32'hA5A5A5A5);

        // AW accepted at once, W delayed two cycles
        step(); req_i = 1'b1; we_i = 1'b1; addr_i = 32'h00000050;
        wdata_i = 32'h12345678; wstrb_i = 4'b0011;
        step(); AWREADY_M = 1'b1; #1;
        check("wdly_c1_ctl", {24'd0, ctl()}, {24'd0, 8'b0011_0001});
        step(); #1;
        check("wdly_c2_ctl", {24'd0, ctl()}, {24'd0, 8'b0001_0001});
        check("wdly_c2_wpayload", {WDATA_M[27:0], WSTRB_M}, {28'h2345678, 4'b0011});
        check("wdly_c2_wlast", {31'd0, WLAST_M}, 32'd1);
        step(); WREADY_M = 1'b1; #1;
        check("wdly_c3_ctl", {24'd0, ctl()}, {24'd0, 8'b0001_0001});
        check("wdly_c3_wdata", WDATA_M, 32'h12345678);
        step(); #1;
        check("wdly_c4_ctl", {24'd0, ctl()}, {24'd0, 8'b0000_1001});
        step(); BVALID_M = 1'b1; #1;
        check("wdly_c5_ctl", {24'd0, ctl()}, {24'd0, 8'b0000_1100});
        check("wdly_rdata_kept", rdata_o, 32'hA5A5A5A5);

        // Reset while R has RVALID pending
        step(); req_i = 1'b1; addr_i = 32'h00000060;
        step(); ARREADY_M = 1'b1;
        step(); #1;
        check("rst_pre_ctl", {24'd0, ctl()}, {24'd0, 8'b0100_0001});
        RVALID_M = 1'b1; RDATA_M = 32'h77777777; ARESET = 1'b1; #1;
        check("rst_mid_ctl", {24'd0, ctl()}, 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        step(); ARESET = 1'b0;
        step(); req_i = 1'b1; addr_i = 32'h00000070; #1;
        check("rst_post_req_ctl", {24'd0, ctl()}, {24'd0, 8'b0000_0001});
        step(); ARREADY_M = 1'b1; #1;
        check("rst_post_ar_addr", ARADDR_M, 32'h00000070);
        step(); RVALID_M = 1'b1; RDATA_M = 32'h0BADF00D; #1;
        check("rst_post_done_ctl", {24'd0, ctl()}, {24'd0, 8'b0100_0100});
        check("rst_post_rdata", rdata_o, 32'h0BADF00D);
        step(); #1;
        check("rst_post_hold", rdata_o, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
